// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: fetch handshake, write-back port, execute hazard info,
// and the registered decoded-instruction outputs towards execute.
interface decode_stage_pipe_if #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
);
  localparam int RW = $clog2(REG_NUM);

  // fetch side
  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_pc;
  // write-back port
  logic            i_wb_en;
  logic [RW-1:0]   i_wb_rd_num;
  logic [XLEN-1:0] i_wb_rd;
  // execute-stage load information
  logic            i_ex_load;
  logic [RW-1:0]   i_ex_rd_num;
  // execute side
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs_1;
  logic [XLEN-1:0] rs_2;
  logic [RW-1:0]   rd_num;
  logic [6:0]      opcode;
  logic [2:0]      func_3;
  logic [6:0]      func_7;
  logic [XLEN-1:0] imm;
  logic            b_taken;
  logic [XLEN-1:0] b_pc;

  // environment side: drives fetch, write-back and execute inputs
  modport master (
    output i_valid, i_inst, i_pc, i_wb_en, i_wb_rd_num, i_wb_rd,
           i_ex_load, i_ex_rd_num, i_ready,
    input  o_ready, o_valid, pc, rs_1, rs_2, rd_num, opcode, func_3,
           func_7, imm, b_taken, b_pc
  );

  // decode stage side
  modport slave (
    input  i_valid, i_inst, i_pc, i_wb_en, i_wb_rd_num, i_wb_rd,
           i_ex_load, i_ex_rd_num, i_ready,
    output o_ready, o_valid, pc, rs_1, rs_2, rd_num, opcode, func_3,
           func_7, imm, b_taken, b_pc
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered RISC-V decode stage: register file with write-back bypass,
// load-use stall, sign-extended immediate, valid/ready output register and
// a one-cycle branch/jump redirect that blocks the wrong-path fetch word.
module decode_stage_pipe #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  decode_stage_pipe_if.slave bus
);
  localparam int RW = $clog2(REG_NUM);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] regs [REG_NUM];
  logic [31:0]     inst;
  logic [6:0]      op;
  logic [RW-1:0]   rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] jalr_sum;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            hazard, ready, accept, transfer;

  logic            valid_reg, b_taken_reg;
  logic [XLEN-1:0] pc_reg, rs1_reg, rs2_reg, imm_reg, b_pc_reg;
  logic [RW-1:0]   rd_reg;
  logic [6:0]      opcode_reg, func7_reg;
  logic [2:0]      func3_reg;

  assign inst = bus.i_inst;
  assign op   = inst[6:0];

  // Two read ports: port 0 takes rs1 (inst[19:15]), port 1 takes rs2 (inst[24:20])
  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    localparam int LSB = (gi == 0) ? 15 : 20;
    logic [RW-1:0]   idx;
    logic [XLEN-1:0] val;
    assign idx = inst[LSB +: RW];
    // x0 reads zero; a same-cycle write-back to the index is forwarded when enabled
    always_comb begin
      if (idx == '0)
        val = '0;
      else if (BYPASS_EN && bus.i_wb_en && (bus.i_wb_rd_num == idx))
        val = bus.i_wb_rd;
      else
        val = regs[idx];
    end
  end

  assign rs1_idx = g_read[0].idx;
  assign rs2_idx = g_read[1].idx;
  assign rs1_val = g_read[0].val;
  assign rs2_val = g_read[1].val;

  // Immediate assembly by format; every format carries inst[31] as its sign bit
  always_comb begin
    imm32 = '0;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                         inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {inst[31:12], 12'b0};
      OP_JAL:                   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                         inst[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
  end

  assign imm_ext  = XLEN'($signed(imm32));
  assign jalr_sum = rs1_val + imm_ext;

  // Branch/jump resolution on the (bypassed) operands; sums wrap at XLEN
  always_comb begin
    taken  = 1'b0;
    target = bus.i_pc + imm_ext;
    case (op)
      OP_JAL:  taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OP_BRANCH: begin
        case (inst[14:12])
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  taken = (rs1_val <  rs2_val);
          3'b111:  taken = (rs1_val >= rs2_val);
          default: taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase
  end

  // A load in execute whose destination matches either source field stalls decode.
  // The redirect cycle also refuses input so the wrong-path word is dropped.
  assign hazard   = bus.i_valid & bus.i_ex_load & (bus.i_ex_rd_num != '0) &
                    ((bus.i_ex_rd_num == rs1_idx) | (bus.i_ex_rd_num == rs2_idx));
  assign ready    = (~valid_reg | bus.i_ready) & ~hazard & ~b_taken_reg;
  assign accept   = bus.i_valid & ready;
  assign transfer = valid_reg & bus.i_ready;

  // Register file: x0 is never written, so it stays zero after reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (bus.i_wb_en && (bus.i_wb_rd_num != '0)) begin
      regs[bus.i_wb_rd_num] <= bus.i_wb_rd;
    end
  end

  // Output pipeline register: load on accept, bubble on transfer, otherwise hold
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_reg   <= 1'b0;
      b_taken_reg <= 1'b0;
      pc_reg      <= '0;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      rd_reg      <= '0;
      opcode_reg  <= '0;
      func3_reg   <= '0;
      func7_reg   <= '0;
      imm_reg     <= '0;
      b_pc_reg    <= '0;
    end else begin
      b_taken_reg <= accept & taken;
      if (accept) begin
        valid_reg  <= 1'b1;
        pc_reg     <= bus.i_pc;
        rs1_reg    <= rs1_val;
        rs2_reg    <= rs2_val;
        rd_reg     <= inst[7 +: RW];
        opcode_reg <= op;
        func3_reg  <= inst[14:12];
        func7_reg  <= inst[31:25];
        imm_reg    <= imm_ext;
        b_pc_reg   <= target;
      end else if (transfer) begin
        valid_reg  <= 1'b0;
      end
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = valid_reg;
  assign bus.pc      = pc_reg;
  assign bus.rs_1    = rs1_reg;
  assign bus.rs_2    = rs2_reg;
  assign bus.rd_num  = rd_reg;
  assign bus.opcode  = opcode_reg;
  assign bus.func_3  = func3_reg;
  assign bus.func_7  = func7_reg;
  assign bus.imm     = imm_reg;
  assign bus.b_taken = b_taken_reg;
  assign bus.b_pc    = b_pc_reg;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: a 32-bit bypassing instance is driven directly,
// and a 64-bit non-bypassing instance mirrors the same stimulus (pc zero-
// extended, write-back data sign-extended) for the width/bypass variants.
module tb_decode_stage_pipe;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 i_clk = ~i_clk;

  decode_stage_pipe_if #(.XLEN(32), .REG_NUM(32)) bus ();
  decode_stage_pipe_if #(.XLEN(64), .REG_NUM(32)) bus64 ();

  decode_stage_pipe #(.XLEN(32), .REG_NUM(32), .BYPASS_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave)
  );
  decode_stage_pipe #(.XLEN(64), .REG_NUM(32), .BYPASS_EN(1'b0)) dut_wide (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus64.slave)
  );

  assign bus64.i_valid     = bus.i_valid;
  assign bus64.i_inst      = bus.i_inst;
  assign bus64.i_pc        = {32'h0, bus.i_pc};
  assign bus64.i_wb_en     = bus.i_wb_en;
  assign bus64.i_wb_rd_num = bus.i_wb_rd_num;
  assign bus64.i_wb_rd     = {{32{bus.i_wb_rd[31]}}, bus.i_wb_rd};
  assign bus64.i_ex_load   = bus.i_ex_load;
  assign bus64.i_ex_rd_num = bus.i_ex_rd_num;
  assign bus64.i_ready     = bus.i_ready;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        taken;
    logic [31:0] bpc;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] num, input logic [31:0] val);
    bus.i_wb_en     = 1'b1;
    bus.i_wb_rd_num = num;
    bus.i_wb_rd     = val;
    step();
    bus.i_wb_en     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.i_valid = 0; bus.i_inst = 0; bus.i_pc = 0; bus.i_wb_en = 0;
    bus.i_wb_rd_num = 0; bus.i_wb_rd = 0; bus.i_ex_load = 0; bus.i_ex_rd_num = 0;
    bus.i_ready = 1;

    //          inst          pc            rs1           rs2       rd     op     f3    f7     imm           tk    bpc
    tbl[0]  = '{32'h00208333, 32'h80,  32'd7,        32'd7,  5'd6,  7'h33, 3'd0, 7'h00, 32'h0,        1'b0, 32'h0};   // add x6,x1,x2
    tbl[1]  = '{32'h40720433, 32'h84,  32'hFFFFFFFB, 32'd3,  5'd8,  7'h33, 3'd0, 7'h20, 32'h0,        1'b0, 32'h0};   // sub x8,x4,x7
    tbl[2]  = '{32'hFFF1A483, 32'h88,  32'h200,      32'd0,  5'd9,  7'h03, 3'd2, 7'h7F, 32'hFFFFFFFF, 1'b0, 32'h0};   // lw x9,-1(x3)
    tbl[3]  = '{32'h0021A423, 32'h8C,  32'h200,      32'd7,  5'd8,  7'h23, 3'd2, 7'h00, 32'h8,        1'b0, 32'h0};   // sw x2,8(x3)
    tbl[4]  = '{32'h80000537, 32'h90,  32'd0,        32'd0,  5'd10, 7'h37, 3'd0, 7'h40, 32'h80000000, 1'b0, 32'h0};   // lui x10,0x80000
    tbl[5]  = '{32'h00208863, 32'h100, 32'd7,        32'd7,  5'd16, 7'h63, 3'd0, 7'h00, 32'h10,       1'b1, 32'h110}; // beq x1,x2,+16
    tbl[6]  = '{32'h00209863, 32'h100, 32'd7,        32'd7,  5'd16, 7'h63, 3'd1, 7'h00, 32'h10,       1'b0, 32'h0};   // bne x1,x2,+16
    tbl[7]  = '{32'hFFD18067, 32'h180, 32'h200,      32'd0,  5'd0,  7'h67, 3'd0, 7'h7F, 32'hFFFFFFFD, 1'b1, 32'h1FC}; // jalr x0,-3(x3)
    tbl[8]  = '{32'hFE724CE3, 32'h200, 32'hFFFFFFFB, 32'd3,  5'd25, 7'h63, 3'd4, 7'h7F, 32'hFFFFFFF8, 1'b1, 32'h1F8}; // blt x4,x7,-8
    tbl[9]  = '{32'hFE726CE3, 32'h200, 32'hFFFFFFFB, 32'd3,  5'd25, 7'h63, 3'd6, 7'h7F, 32'hFFFFFFF8, 1'b0, 32'h0};   // bltu x4,x7,-8
    tbl[10] = '{32'h008000EF, 32'h300, 32'd0,        32'd0,  5'd1,  7'h6F, 3'd0, 7'h00, 32'h8,        1'b1, 32'h308}; // jal x1,+8
    tbl[11] = '{32'hFFF08293, 32'h304, 32'd7,        32'd0,  5'd5,  7'h13, 3'd0, 7'h7F, 32'hFFFFFFFF, 1'b0, 32'h0};   // addi x5,x1,-1

    // reset held two cycles
    i_rst = 1'b0;
    step(); step();
    check("reset o_valid", bus.o_valid, 0);
    check("reset b_taken", bus.b_taken, 0);
    check("reset rs_1", bus.rs_1, 0);
    check("reset wide o_valid", bus64.o_valid, 0);
    i_rst = 1'b1;
    #1;
    check("reset o_ready", bus.o_ready, 1);
    $display("txn reset done");

    // read x5 after reset: add x6,x5,x0
    bus.i_valid = 1; bus.i_inst = 32'h00028333; bus.i_pc = 32'h10;
    step();
    check("x5 after reset valid", bus.o_valid, 1);
    check("x5 after reset rs_1", bus.rs_1, 0);
    $display("txn read x5 after reset rs_1=%0h", bus.rs_1);

    // write x5 in the same cycle the reader is accepted
    bus.i_wb_en = 1; bus.i_wb_rd_num = 5; bus.i_wb_rd = 32'h1234;
    step();
    bus.i_wb_en = 0;
    check("bypass rs_1", bus.rs_1, 32'h1234);
    check("no-bypass wide rs_1", bus64.rs_1, 0);
    $display("txn bypass rs_1=%0h wide rs_1=%0h", bus.rs_1, bus64.rs_1);
    step();
    check("stored x5 rs_1", bus.rs_1, 32'h1234);
    check("stored x5 wide rs_1", bus64.rs_1, 64'h1234);

    // write to x0 is ignored, both when forwarded and when stored
    bus.i_inst = 32'h00000333;
    bus.i_wb_en = 1; bus.i_wb_rd_num = 0; bus.i_wb_rd = 32'hFFFF;
    step();
    bus.i_wb_en = 0;
    check("x0 same-cycle rs_1", bus.rs_1, 0);
    step();
    check("x0 stored rs_1", bus.rs_1, 0);
    $display("txn x0 write ignored rs_1=%0h", bus.rs_1);
    bus.i_valid = 0;
    step();
    check("bubble o_valid", bus.o_valid, 0);

    // load-use stall on x5
    bus.i_valid = 1; bus.i_inst = 32'h00028333; bus.i_pc = 32'h20;
    bus.i_ex_load = 1; bus.i_ex_rd_num = 5;
    #1;
    check("load-use o_ready", bus.o_ready, 0);
    step();
    check("load-use bubble o_valid", bus.o_valid, 0);
    step();
    check("load-use hold o_valid", bus.o_valid, 0);
    bus.i_ex_load = 0;
    #1;
    check("load-use release o_ready", bus.o_ready, 1);
    step();
    check("load-use accept o_valid", bus.o_valid, 1);
    check("load-use accept rs_1", bus.rs_1, 32'h1234);
    check("load-use accept pc", bus.pc, 32'h20);
    $display("txn load-use retried pc=%0h", bus.pc);
    // a load to x0 never stalls
    bus.i_inst = 32'h00000333; bus.i_ex_load = 1; bus.i_ex_rd_num = 0;
    #1;
    check("load x0 no stall o_ready", bus.o_ready, 1);
    step();
    bus.i_valid = 0; bus.i_ex_load = 0;
    step();

    // preload operand registers
    wb(5'd1, 32'd7);
    wb(5'd2, 32'd7);
    wb(5'd3, 32'h200);
    wb(5'd4, 32'hFFFFFFFB);
    wb(5'd7, 32'd3);

    // backpressure: hold an add while the next word waits
    bus.i_ready = 0;
    bus.i_valid = 1; bus.i_inst = 32'h00208333; bus.i_pc = 32'h40;
    step();
    bus.i_inst = 32'h40720433; bus.i_pc = 32'h44;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d o_ready", k), bus.o_ready, 0);
      step();
      check($sformatf("stall%0d o_valid", k), bus.o_valid, 1);
      check($sformatf("stall%0d pc", k), bus.pc, 32'h40);
      check($sformatf("stall%0d rs_1", k), bus.rs_1, 32'd7);
      check($sformatf("stall%0d rs_2", k), bus.rs_2, 32'd7);
      check($sformatf("stall%0d rd_num", k), bus.rd_num, 6);
      $display("txn backpressure cycle %0d pc=%0h", k, bus.pc);
    end
    bus.i_ready = 1;
    #1;
    check("stall release o_ready", bus.o_ready, 1);
    step();
    check("after stall pc", bus.pc, 32'h44);
    check("after stall rd_num", bus.rd_num, 8);
    check("after stall func_7", bus.func_7, 7'h20);
    bus.i_valid = 0;
    step();

    // decode table
    for (int i = 0; i < 12; i++) begin
      bus.i_valid = 1; bus.i_inst = tbl[i].inst; bus.i_pc = tbl[i].pc;
      step();
      bus.i_valid = 0;
      #1;
      check($sformatf("v%0d o_valid", i), bus.o_valid, 1);
      check($sformatf("v%0d pc", i), bus.pc, tbl[i].pc);
      check($sformatf("v%0d rs_1", i), bus.rs_1, tbl[i].rs1);
      check($sformatf("v%0d rs_2", i), bus.rs_2, tbl[i].rs2);
      check($sformatf("v%0d rd_num", i), bus.rd_num, tbl[i].rd);
      check($sformatf("v%0d opcode", i), bus.opcode, tbl[i].op);
      check($sformatf("v%0d func_3", i), bus.func_3, tbl[i].f3);
      check($sformatf("v%0d func_7", i), bus.func_7, tbl[i].f7);
      check($sformatf("v%0d imm", i), bus.imm, tbl[i].imm);
      check($sformatf("v%0d b_taken", i), bus.b_taken, tbl[i].taken);
      check($sformatf("v%0d o_ready", i), bus.o_ready, !tbl[i].taken);
      if (tbl[i].taken)
        check($sformatf("v%0d b_pc", i), bus.b_pc, tbl[i].bpc);
      check($sformatf("v%0d wide imm", i), bus64.imm, sx(tbl[i].imm));
      check($sformatf("v%0d wide rs_1", i), bus64.rs_1, sx(tbl[i].rs1));
      check($sformatf("v%0d wide b_taken", i), bus64.b_taken, tbl[i].taken);
      $display("txn v%0d inst=%08h pc=%0h imm=%08h b_taken=%0b b_pc=%0h",
               i, tbl[i].inst, bus.pc, bus.imm, bus.b_taken, bus.b_pc);
      step();
      check($sformatf("v%0d pulse end b_taken", i), bus.b_taken, 0);
      check($sformatf("v%0d drained o_valid", i), bus.o_valid, 0);
    end

    // reset while a taken branch and its redirect are in flight
    bus.i_valid = 1; bus.i_inst = 32'h00208863; bus.i_pc = 32'h100;
    step();
    bus.i_valid = 0;
    check("mid-reset pre b_taken", bus.b_taken, 1);
    i_rst = 1'b0;
    step();
    check("mid-reset o_valid", bus.o_valid, 0);
    check("mid-reset b_taken", bus.b_taken, 0);
    check("mid-reset b_pc", bus.b_pc, 0);
    check("mid-reset pc", bus.pc, 0);
    i_rst = 1'b1;
    bus.i_valid = 1; bus.i_inst = 32'h00208333; bus.i_pc = 32'h50;
    step();
    bus.i_valid = 0;
    check("post-reset x1", bus.rs_1, 0);
    check("post-reset x2", bus.rs_2, 0);
    check("post-reset wide x1", bus64.rs_1, 0);
    $display("txn reset mid-stream rs_1=%0h", bus.rs_1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
